// File: rtl/adc_scan_pkg.sv
// Shared types and LTC2308 helpers for the ADC scan controller.
`timescale 1ns/1ps
package adc_scan_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CONV  = 2'd1,
    SHIFT = 2'd2,
    ACQ   = 2'd3
  } scan_state_t;

  localparam logic SD_SINGLE    = 1'b1;
  localparam logic UNI_UNIPOLAR = 1'b1;
  localparam logic SLP_OFF      = 1'b0;

  localparam int FRAME_BITS = 12;
  localparam int CFG_BITS   = 6;

  // LTC2308 config word: {S/D, O/S, S1, S0, UNI, SLP}; O/S carries the channel LSB.
  function automatic logic [5:0] cfg_word(input logic [2:0] ch);
    return {SD_SINGLE, ch[0], ch[2], ch[1], UNI_UNIPOLAR, SLP_OFF};
  endfunction

  // Next enabled channel strictly after cur; i=8 wraps back to cur itself.
  function automatic logic [2:0] next_ch(input logic [2:0] cur, input logic [7:0] mask);
    logic [2:0] cand;
    logic [2:0] sel;
    sel = cur;
    for (int i = 8; i >= 1; i--) begin
      cand = cur + 3'(i);
      if (mask[cand]) sel = cand;
    end
    return sel;
  endfunction

endpackage

// File: rtl/adc_spi_shifter.sv
// SCLK divider and 12-bit SPI engine: shifts the config word out on DIN and
// the conversion result in from DOUT.
`timescale 1ns/1ps
module adc_spi_shifter
  import adc_scan_pkg::*;
#(
  parameter int SCLK_HALF = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [5:0]  cfg,
  input  logic        dout,
  output logic        done,
  output logic [11:0] data,
  output logic        sclk,
  output logic        din
);

  localparam int HALF_W = (SCLK_HALF > 1) ? $clog2(SCLK_HALF) : 1;
  localparam int LAST_EDGE = 2 * FRAME_BITS - 1;

  logic              active;
  logic [HALF_W-1:0] half_cnt;
  logic [4:0]        edge_cnt;
  logic [5:0]        tx;
  logic [11:0]       rx;
  logic              half_end;

  assign half_end = active && (half_cnt == HALF_W'(SCLK_HALF - 1));
  assign done     = half_end && (edge_cnt == 5'(LAST_EDGE));
  assign data     = rx;

  // Rising SCLK samples DOUT; falling SCLK advances DIN, which zero-fills after the config bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      active   <= 1'b0;
      half_cnt <= '0;
      edge_cnt <= '0;
      tx       <= '0;
      rx       <= '0;
      sclk     <= 1'b0;
      din      <= 1'b0;
    end else if (start) begin
      active   <= 1'b1;
      half_cnt <= '0;
      edge_cnt <= '0;
      sclk     <= 1'b0;
      din      <= cfg[5];
      tx       <= {cfg[4:0], 1'b0};
    end else if (half_end) begin
      half_cnt <= '0;
      edge_cnt <= edge_cnt + 5'd1;
      sclk     <= ~sclk;
      if (!sclk) begin
        rx <= {rx[10:0], dout};
      end else begin
        din <= tx[5];
        tx  <= {tx[4:0], 1'b0};
      end
      if (edge_cnt == 5'(LAST_EDGE)) active <= 1'b0;
    end else if (active) begin
      half_cnt <= half_cnt + HALF_W'(1);
    end
  end

endmodule

// File: rtl/adc_scan_ctrl.sv
// Round-robin LTC2308 scan controller: CONV/SHIFT/ACQ frame sequencing,
// channel rotation, per-channel result register file and sample strobe.
`timescale 1ns/1ps
module adc_scan_ctrl
  import adc_scan_pkg::*;
#(
  parameter int CONV_CYCLES = 80,
  parameter int SCLK_HALF   = 2,
  parameter int ACQ_CYCLES  = 12
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable_i,
  input  logic [7:0]  ch_en_i,
  output logic        adc_convst_o,
  output logic        adc_sclk_o,
  output logic        adc_din_o,
  input  logic        adc_dout_i,
  output logic        sample_valid_o,
  output logic [2:0]  sample_ch_o,
  output logic [11:0] sample_data_o,
  input  logic [2:0]  rd_ch_i,
  output logic [11:0] rd_data_o,
  output logic        busy_o
);

  localparam int CNT_W = 16;

  scan_state_t state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       cur_ch;
  logic [2:0]       prev_ch;
  logic             priming;
  logic [11:0]      regfile [8];

  logic             go;
  logic             shift_start;
  logic             shift_done;
  logic [11:0]      shift_data;

  assign go          = enable_i && (ch_en_i != 8'h00);
  assign shift_start = (state == CONV) && (cnt == CNT_W'(CONV_CYCLES - 1));
  assign rd_data_o   = regfile[rd_ch_i];

  adc_spi_shifter #(
    .SCLK_HALF (SCLK_HALF)
  ) u_shifter (
    .clk   (clk),
    .rst   (rst),
    .start (shift_start),
    .cfg   (cfg_word(cur_ch)),
    .dout  (adc_dout_i),
    .done  (shift_done),
    .data  (shift_data),
    .sclk  (adc_sclk_o),
    .din   (adc_din_o)
  );

  // Data returned in a frame belongs to the channel configured one frame earlier,
  // so each select point shifts cur_ch into prev_ch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      cnt            <= '0;
      cur_ch         <= 3'd7;
      prev_ch        <= 3'd7;
      priming        <= 1'b0;
      adc_convst_o   <= 1'b0;
      busy_o         <= 1'b0;
      sample_valid_o <= 1'b0;
      sample_ch_o    <= '0;
      sample_data_o  <= '0;
    end else begin
      sample_valid_o <= 1'b0;
      case (state)
        IDLE: begin
          if (go) begin
            state        <= CONV;
            cnt          <= '0;
            adc_convst_o <= 1'b1;
            busy_o       <= 1'b1;
            priming      <= 1'b1;
            prev_ch      <= cur_ch;
            cur_ch       <= next_ch(cur_ch, ch_en_i);
          end
        end
        CONV: begin
          if (cnt == CNT_W'(CONV_CYCLES - 1)) begin
            state        <= SHIFT;
            cnt          <= '0;
            adc_convst_o <= 1'b0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        SHIFT: begin
          if (shift_done) begin
            state   <= ACQ;
            cnt     <= '0;
            priming <= 1'b0;
            if (!priming) begin
              sample_valid_o <= 1'b1;
              sample_ch_o    <= prev_ch;
              sample_data_o  <= shift_data;
            end
          end
        end
        ACQ: begin
          if (cnt == CNT_W'(ACQ_CYCLES - 1)) begin
            cnt <= '0;
            if (go) begin
              state        <= CONV;
              adc_convst_o <= 1'b1;
              prev_ch      <= cur_ch;
              cur_ch       <= next_ch(cur_ch, ch_en_i);
            end else begin
              state  <= IDLE;
              busy_o <= 1'b0;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
          state        <= IDLE;
          busy_o       <= 1'b0;
          adc_convst_o <= 1'b0;
        end
      endcase
    end
  end

  // The register file is written from the strobe registers, so reads see it one cycle later.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) regfile[i] <= '0;
    end else if (sample_valid_o) begin
      regfile[sample_ch_o] <= sample_data_o;
    end
  end

endmodule

// File: tb/tb_adc_scan_ctrl.sv
// Self-checking bench for adc_scan_ctrl with an LTC2308 behavioural model and strobe scoreboard.
`timescale 1ns/1ps
module tb_adc_scan_ctrl;

  localparam int CONV_CYCLES = 80;
  localparam int SCLK_HALF   = 2;
  localparam int ACQ_CYCLES  = 12;
  localparam int FRAME       = CONV_CYCLES + 24 * SCLK_HALF + ACQ_CYCLES;
  localparam int PRIME_DELAY = FRAME + CONV_CYCLES + 24 * SCLK_HALF;

  logic        clk;
  logic        rst;
  logic        enable_i;
  logic [7:0]  ch_en_i;
  logic        adc_convst_o;
  logic        adc_sclk_o;
  logic        adc_din_o;
  logic        adc_dout_i;
  logic        sample_valid_o;
  logic [2:0]  sample_ch_o;
  logic [11:0] sample_data_o;
  logic [2:0]  rd_ch_i;
  logic [11:0] rd_data_o;
  logic        busy_o;

  typedef struct {
    logic [2:0]  ch;
    logic [11:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   tests_run    = 0;
  int   tests_failed = 0;
  int   strobe_count = 0;
  logic mode_const   = 1'b1;
  logic din_check_en = 1'b0;

  adc_scan_ctrl #(
    .CONV_CYCLES (CONV_CYCLES),
    .SCLK_HALF   (SCLK_HALF),
    .ACQ_CYCLES  (ACQ_CYCLES)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .enable_i       (enable_i),
    .ch_en_i        (ch_en_i),
    .adc_convst_o   (adc_convst_o),
    .adc_sclk_o     (adc_sclk_o),
    .adc_din_o      (adc_din_o),
    .adc_dout_i     (adc_dout_i),
    .sample_valid_o (sample_valid_o),
    .sample_ch_o    (sample_ch_o),
    .sample_data_o  (sample_data_o),
    .rd_ch_i        (rd_ch_i),
    .rd_data_o      (rd_data_o),
    .busy_o         (busy_o)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic apply_stimulus(input logic en, input logic [7:0] mask);
    enable_i = en;
    ch_en_i  = mask;
  endtask

  task automatic push_exp(input logic [2:0] ch, input logic [11:0] data);
    exp_t e;
    e.ch   = ch;
    e.data = data;
    exp_q.push_back(e);
  endtask

  task automatic wait_strobes(input int target, input int budget, input string tag);
    for (int i = 0; i < budget && strobe_count < target; i++) @(negedge clk);
    check_output(tag, 32'(strobe_count >= target), 32'd1);
  endtask

  task automatic wait_idle(input int budget, input string tag);
    for (int i = 0; i < budget && busy_o; i++) @(negedge clk);
    check_output(tag, 32'(busy_o), 32'd0);
  endtask

  task automatic wait_convst(input int budget, input string tag);
    for (int i = 0; i < budget && !adc_convst_o; i++) @(negedge clk);
    check_output(tag, 32'(adc_convst_o), 32'd1);
  endtask

  task automatic wait_sclk(input int budget, input string tag);
    for (int i = 0; i < budget && !adc_sclk_o; i++) @(negedge clk);
    check_output(tag, 32'(adc_sclk_o), 32'd1);
  endtask

  task automatic check_rd(input logic [2:0] ch, input logic [11:0] exp, input string tag);
    rd_ch_i = ch;
    #1;
    check_output(tag, 32'(rd_data_o), 32'(exp));
  endtask

  // ADC model plus pin-level monitor, sampled on the falling clk edge.
  initial begin
    int          cyc;
    int          run;
    int          rise_cnt;
    int          busy_rise_cyc;
    int          last_strobe_cyc;
    logic        first_pending;
    logic        have_last;
    logic        in_frame;
    logic        prev_sclk;
    logic        prev_convst;
    logic        prev_busy;
    logic        prev_din;
    logic        prev_valid;
    logic [11:0] model_sh;
    logic [11:0] din_word;
    logic [2:0]  last_cfg_ch;
    exp_t        e;
    cyc = 0; run = 0; rise_cnt = 0; busy_rise_cyc = 0; last_strobe_cyc = 0;
    first_pending = 1'b0; have_last = 1'b0; in_frame = 1'b0;
    prev_sclk = 1'b0; prev_convst = 1'b0; prev_busy = 1'b0; prev_din = 1'b0; prev_valid = 1'b0;
    model_sh = '0; din_word = '0; last_cfg_ch = 3'd7;
    adc_dout_i = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        first_pending = 1'b0; have_last = 1'b0; in_frame = 1'b0; run = 0;
        prev_sclk = 1'b0; prev_convst = 1'b0; prev_busy = 1'b0; prev_din = 1'b0; prev_valid = 1'b0;
      end else begin
        if (in_frame && ((adc_convst_o && !prev_convst) || (!busy_o && prev_busy))) begin
          check_output("sclk_pulses", 32'(rise_cnt), 32'd12);
          in_frame = 1'b0;
        end
        if (prev_convst && !adc_convst_o) begin
          in_frame = 1'b1;
          rise_cnt = 0;
          din_word = '0;
          model_sh = mode_const ? 12'hA5C : (12'h100 + {9'b0, last_cfg_ch});
          adc_dout_i = model_sh[11];
        end
        if (adc_convst_o) begin
          run = 0;
        end else if (adc_sclk_o != prev_sclk) begin
          check_output(prev_sclk ? "sclk_high_len" : "sclk_low_len", 32'(run), 32'(SCLK_HALF));
          run = 1;
          if (adc_sclk_o) begin
            rise_cnt++;
            check_output("din_stable", 32'(adc_din_o), 32'(prev_din));
            din_word = {din_word[10:0], adc_din_o};
            if (rise_cnt == 6) last_cfg_ch = {din_word[3], din_word[2], din_word[4]};
            if (rise_cnt == 12 && din_check_en) check_output("din_word", 32'(din_word), 32'h880);
          end else begin
            model_sh = {model_sh[10:0], 1'b0};
            adc_dout_i = model_sh[11];
          end
        end else begin
          run++;
        end
        if (busy_o && !prev_busy) begin
          busy_rise_cyc = cyc;
          first_pending = 1'b1;
        end
        if (sample_valid_o) begin
          strobe_count++;
          check_output("valid_width", 32'(prev_valid), 32'd0);
          if (first_pending) check_output("prime_delay", 32'(cyc - busy_rise_cyc), 32'(PRIME_DELAY));
          else if (have_last) check_output("strobe_period", 32'(cyc - last_strobe_cyc), 32'(FRAME));
          first_pending = 1'b0;
          have_last = 1'b1;
          last_strobe_cyc = cyc;
          check_output("strobe_expected", 32'(exp_q.size() != 0), 32'd1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check_output("strobe_ch", 32'(sample_ch_o), 32'(e.ch));
            check_output("strobe_data", 32'(sample_data_o), 32'(e.data));
          end
        end
        prev_sclk = adc_sclk_o;
        prev_convst = adc_convst_o;
        prev_busy = busy_o;
        prev_din = adc_din_o;
        prev_valid = sample_valid_o;
      end
    end
  end

  initial begin
    int base;
    int convst_seen;
    rst = 1'b1;
    rd_ch_i = 3'd0;
    apply_stimulus(1'b0, 8'h00);
    repeat (3) @(negedge clk);
    check_output("rst_convst", 32'(adc_convst_o), 32'd0);
    check_output("rst_sclk", 32'(adc_sclk_o), 32'd0);
    check_output("rst_din", 32'(adc_din_o), 32'd0);
    check_output("rst_valid", 32'(sample_valid_o), 32'd0);
    check_output("rst_ch", 32'(sample_ch_o), 32'd0);
    check_output("rst_data", 32'(sample_data_o), 32'd0);
    check_output("rst_busy", 32'(busy_o), 32'd0);
    check_output("rst_rd", 32'(rd_data_o), 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check_output("idle_busy", 32'(busy_o), 32'd0);

    // single channel 0, constant model data
    din_check_en = 1'b1;
    for (int i = 0; i < 3; i++) push_exp(3'd0, 12'hA5C);
    base = strobe_count;
    apply_stimulus(1'b1, 8'h01);
    wait_strobes(base + 3, 800, "t1_strobes");
    apply_stimulus(1'b0, 8'h01);
    din_check_en = 1'b0;
    wait_idle(40, "t1_idle");
    check_rd(3'd0, 12'hA5C, "t1_rd0");

    // channels 2, 5, 7 rotating
    @(negedge clk);
    mode_const = 1'b0;
    for (int i = 0; i < 2; i++) begin
      push_exp(3'd2, 12'h102);
      push_exp(3'd5, 12'h105);
      push_exp(3'd7, 12'h107);
    end
    base = strobe_count;
    apply_stimulus(1'b1, 8'b1010_0100);
    wait_strobes(base + 6, 1300, "t2_strobes");
    apply_stimulus(1'b0, 8'b1010_0100);
    wait_idle(40, "t2_idle");
    check_rd(3'd2, 12'h102, "t2_rd2");
    check_rd(3'd5, 12'h105, "t2_rd5");
    check_rd(3'd7, 12'h107, "t2_rd7");
    check_rd(3'd0, 12'hA5C, "t2_rd0");

    // enable dropped mid-SHIFT
    @(negedge clk);
    push_exp(3'd1, 12'h101);
    push_exp(3'd1, 12'h101);
    base = strobe_count;
    apply_stimulus(1'b1, 8'h02);
    wait_strobes(base + 1, 400, "t3_first");
    wait_convst(200, "t3_conv");
    wait_sclk(200, "t3_shift");
    apply_stimulus(1'b0, 8'h02);
    wait_strobes(base + 2, 200, "t3_last");
    wait_idle(20, "t3_idle");
    convst_seen = 0;
    repeat (300) begin
      @(negedge clk);
      if (adc_convst_o) convst_seen++;
    end
    check_output("t3_no_convst", 32'(convst_seen), 32'd0);
    check_output("t3_busy_low", 32'(busy_o), 32'd0);

    // mask switched from ch0 to ch7 mid-frame
    for (int i = 0; i < 3; i++) push_exp(3'd0, 12'h100);
    push_exp(3'd7, 12'h107);
    push_exp(3'd7, 12'h107);
    base = strobe_count;
    apply_stimulus(1'b1, 8'h01);
    wait_strobes(base + 1, 400, "t4_first");
    wait_convst(200, "t4_conv");
    apply_stimulus(1'b1, 8'h80);
    wait_strobes(base + 5, 800, "t4_strobes");
    apply_stimulus(1'b0, 8'h80);
    wait_idle(40, "t4_idle");
    check_rd(3'd7, 12'h107, "t4_rd7");
    check_rd(3'd0, 12'h100, "t4_rd0");

    // reset asserted mid-CONV
    @(negedge clk);
    apply_stimulus(1'b1, 8'h80);
    wait_convst(20, "t5_conv");
    repeat (10) @(negedge clk);
    #3 rst = 1'b1;
    #1;
    check_output("t5_convst", 32'(adc_convst_o), 32'd0);
    check_output("t5_busy", 32'(busy_o), 32'd0);
    check_output("t5_sclk", 32'(adc_sclk_o), 32'd0);
    check_output("t5_din", 32'(adc_din_o), 32'd0);
    check_output("t5_valid", 32'(sample_valid_o), 32'd0);
    check_output("t5_ch", 32'(sample_ch_o), 32'd0);
    check_output("t5_data", 32'(sample_data_o), 32'd0);
    @(negedge clk);
    for (int i = 0; i < 8; i++) check_rd(3'(i), 12'h000, "t5_rd_clear");
    push_exp(3'd7, 12'h107);
    base = strobe_count;
    @(negedge clk);
    rst = 1'b0;
    wait_strobes(base + 1, 400, "t5_strobe");
    apply_stimulus(1'b0, 8'h80);
    wait_idle(40, "t5_idle");

    check_output("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
